// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction-memory port, hazard/branch controls and the IF/ID register outputs.
// master = fetch stage, slave = the surrounding pipeline / memory.
interface fetch_stage_if;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;

    modport master (
        output pc_out,
        output if_id_instr,
        output if_id_pc_plus4,
        output if_id_valid,
        input  instr_in,
        input  stall,
        input  branch_taken,
        input  branch_target
    );

    modport slave (
        input  pc_out,
        input  if_id_instr,
        input  if_id_pc_plus4,
        input  if_id_valid,
        output instr_in,
        output stall,
        output branch_taken,
        output branch_target
    );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, PC+4, IF/ID register with stall and branch flush.
// Optional early jump decode in IF is enabled by defining FETCH_EARLY_JUMP_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    fetch_stage_if.master        bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pp4_q, pp4_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_plus4;

    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        pc_d     = pc_plus4;
        instr_d  = bus.instr_in;
        pp4_d    = pc_plus4;
        valid_d  = 1'b1;
        // Branch beats stall: redirect and flush even while the hazard unit asks to hold.
        if (bus.branch_taken) begin
            pc_d    = bus.branch_target & ~32'h3;
            instr_d = NOP_INSTR;
            pp4_d   = 32'h0;
            valid_d = 1'b0;
        end else if (bus.stall) begin
            pc_d    = pc_q;
            instr_d = instr_q;
            pp4_d   = pp4_q;
            valid_d = valid_q;
        end
`ifdef FETCH_EARLY_JUMP_EN
        else if (bus.instr_in[31:26] == 6'b000010) begin
            // The jump word still enters IF/ID; only the PC is steered.
            pc_d = {pc_plus4[31:28], bus.instr_in[25:0], 2'b00};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pp4_q   <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pp4_q   <= pp4_d;
            valid_q <= valid_d;
        end
    end

    assign bus.pc_out         = pc_q;
    assign bus.if_id_instr    = instr_q;
    assign bus.if_id_pc_plus4 = pp4_q;
    assign bus.if_id_valid    = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then randomized stall/branch/reset traffic,
// all checked against a behavioural PC/IF-ID model with a 1 KB instruction memory array.
module tb_fetch_stage;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_stage_if bus ();
    fetch_stage_if bus_w ();

    logic [31:0] mem [256];

    assign bus.instr_in   = mem[bus.pc_out[9:2]];
    assign bus_w.instr_in = mem[bus_w.pc_out[9:2]];
    assign bus_w.stall         = 1'b0;
    assign bus_w.branch_taken  = 1'b0;
    assign bus_w.branch_target = 32'h0;

    fetch_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    fetch_stage #(
        .RESET_PC (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w.master)
    );

`ifdef FETCH_EARLY_JUMP_EN
    localparam bit JumpEn = 1'b1;
`else
    localparam bit JumpEn = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        logic [31:0] word;
        if (reset) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
        end else if (bus.branch_taken) begin
            m_pc = {bus.branch_target[31:2], 2'b00};
            m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
        end else if (!bus.stall) begin
            word    = mem[m_pc[9:2]];
            m_instr = word;
            m_pp4   = m_pc + 32'd4;
            m_valid = 1'b1;
            if (JumpEn && word[31:26] == 6'd2)
                m_pc = {m_pp4[31:28], word[25:0], 2'b00};
            else
                m_pc = m_pp4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("pc", bus.pc_out, m_pc);
        check_eq("instr", bus.if_id_instr, m_instr);
        check_eq("pp4", bus.if_id_pc_plus4, m_pp4);
        check_eq("valid", {31'h0, bus.if_id_valid}, {31'h0, m_valid});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h8E96_0001;
        mem[1] = 32'h02C5_2020;
        mem[4] = 32'h0800_0010;
        m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;

        reset = 1'b1;
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 32'h0;
        #2;

        // Reset held two cycles
        tick();
        tick();
        check_eq("rst_pc", bus.pc_out, 32'h0);
        check_eq("rst_valid", {31'h0, bus.if_id_valid}, 32'h0);
        check_eq("rst_instr", bus.if_id_instr, 32'h0);
        check_eq("wrap_rst_pc", bus_w.pc_out, 32'hFFFF_FFFC);

        // First fetch
        reset = 1'b0;
        tick();
        check_eq("first_pc", bus.pc_out, 32'h4);
        check_eq("first_instr", bus.if_id_instr, 32'h8E96_0001);
        check_eq("first_pp4", bus.if_id_pc_plus4, 32'h4);
        check_eq("first_valid", {31'h0, bus.if_id_valid}, 32'h1);
        check_eq("wrap_pc", bus_w.pc_out, 32'h0);
        check_eq("wrap_pp4", bus_w.if_id_pc_plus4, 32'h0);

        // Load-use stall at pc 8
        tick();
        check_eq("pre_stall_pc", bus.pc_out, 32'h8);
        bus.stall = 1'b1;
        repeat (2) begin
            tick();
            check_eq("stall_pc", bus.pc_out, 32'h8);
            check_eq("stall_instr", bus.if_id_instr, 32'h02C5_2020);
            check_eq("stall_pp4", bus.if_id_pc_plus4, 32'h8);
        end
        bus.stall = 1'b0;
        tick();
        check_eq("release_pc", bus.pc_out, 32'hC);
        check_eq("release_instr", bus.if_id_instr, mem[2]);

        // Misaligned branch target
        bus.branch_taken = 1'b1;
        bus.branch_target = 32'h43;
        tick();
        check_eq("br_pc", bus.pc_out, 32'h40);
        check_eq("br_valid", {31'h0, bus.if_id_valid}, 32'h0);
        check_eq("br_instr", bus.if_id_instr, 32'h0);
        bus.branch_taken = 1'b0;
        tick();
        check_eq("br_next_instr", bus.if_id_instr, mem[16]);
        check_eq("br_next_pp4", bus.if_id_pc_plus4, 32'h44);

        // Branch and stall together
        bus.branch_taken = 1'b1;
        bus.stall = 1'b1;
        bus.branch_target = 32'h20;
        tick();
        check_eq("brst_pc", bus.pc_out, 32'h20);
        check_eq("brst_valid", {31'h0, bus.if_id_valid}, 32'h0);

        // Jump word at 0x10
        bus.stall = 1'b0;
        bus.branch_target = 32'h10;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        check_eq("jmp_pc", bus.pc_out, JumpEn ? 32'h40 : 32'h14);
        check_eq("jmp_instr", bus.if_id_instr, 32'h0800_0010);
        check_eq("jmp_valid", {31'h0, bus.if_id_valid}, 32'h1);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) < 2);
            bus.stall = ($urandom_range(0, 99) < 25);
            bus.branch_taken = ($urandom_range(0, 99) < 10);
            bus.branch_target = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
